// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed program store answering one
// fetch at a time after a fixed latency, with a program-load side port and flush.
module imem_responder #(
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  // state | meaning
  // IDLE  | ready to accept a fetch
  // WAIT  | fetch accepted, counting down the remaining latency
  // RESP  | response presented, held until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);

  logic [31:0] mem_q [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [31:0]   acc_off;
  logic [31:0]   acc_word;
  logic [AW-1:0] acc_idx;
  logic          acc_err;

  // Addresses below BASE wrap to a huge word index and fall out of range.
  assign acc_off  = req_addr - BASE;
  assign acc_word = {2'b00, acc_off[31:2]};
  assign acc_idx  = acc_off[AW+1:2];
  assign acc_err  = (req_addr[1:0] != 2'b00) | (acc_word >= 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (prog_we) mem_q[prog_addr] <= prog_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // mem_q still holds the pre-write word on a same-edge program load
            data_d = acc_err ? 32'h0 : mem_q[acc_idx];
            err_d  = acc_err;
            if (LATENCY == 1) begin
              state_d = RESP;
            end else begin
              state_d = WAIT;
              cnt_d   = CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) state_d = RESP;
          else               cnt_d   = cnt_q - 4'd1;
        end
        RESP: begin
          if (rsp_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE) & ~flush;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: fixed vectors, hand-written corner
// sequences and randomized fetches against an array-based reference model.
module tb_imem_responder;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 1024;
  localparam int          LATENCY = 2;
  localparam int          AW      = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_data;
  logic          rsp_err;
  logic          rsp_ready;
  logic          flush;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [31:0]   prog_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [31:0] addr;
    logic        err;
    logic [31:0] data;
  } vec_t;
  vec_t vecs [9];

  imem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready),
    .flush     (flush),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: fetch result from plain address arithmetic on the model store.
  function automatic void model_fetch(input logic [31:0] a, output logic e, output logic [31:0] d);
    logic [31:0] off;
    logic [31:0] widx;
    off  = a - BASE;
    widx = off >> 2;
    e    = (a[1:0] != 2'b00) || (widx >= 32'(DEPTH));
    d    = e ? 32'h0 : model_mem[widx[AW-1:0]];
  endfunction

  task automatic prog_write(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Called and returns just after a falling edge with the DUT idle.
  task automatic do_fetch(input logic [31:0] addr, input logic exp_e, input logic [31:0] exp_d,
                          input bit we, input logic [AW-1:0] wa, input logic [31:0] wd,
                          input int stall, input string tag);
    int cnt;
    logic [AW-1:0] fidx;
    fidx = AW'((addr - BASE) >> 2);
    chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = addr; rsp_ready = (stall == 0);
    prog_we = we; prog_addr = wa; prog_data = wd;
    @(negedge clk);
    req_valid = 1'b0; prog_we = 1'b0;
    if (we) model_mem[wa] = wd;
    cnt = 0;
    while (!rsp_valid && cnt < 32) begin
      chk({tag, "_req_ready_busy"}, 32'(req_ready), 32'd0);
      @(negedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(LATENCY - 1));
    chk({tag, "_data"}, rsp_data, exp_d);
    chk({tag, "_err"}, 32'(rsp_err), 32'(exp_e));
    if (stall > 0) rsp_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      prog_we   = ($urandom_range(0, 1) == 1);
      prog_addr = ($urandom_range(0, 1) == 1) ? fidx : AW'($urandom);
      prog_data = $urandom;
      @(negedge clk);
      if (prog_we) model_mem[prog_addr] = prog_data;
      prog_we = 1'b0;
      chk({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_hold_data"}, rsp_data, exp_d);
      chk({tag, "_hold_err"}, 32'(rsp_err), 32'(exp_e));
      chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic fetch_model(input logic [31:0] addr, input int stall, input string tag);
    logic e;
    logic [31:0] d;
    model_fetch(addr, e, d);
    do_fetch(addr, e, d, 1'b0, '0, 32'h0, stall, tag);
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    flush = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) prog_write(AW'(i), $urandom);
    prog_write(AW'(0), 32'h0010_0093);
    prog_write(AW'(1), 32'h0020_0113);
    prog_write(AW'(DEPTH - 1), 32'hCAFE_F00D);

    vecs[0] = '{32'h8000_0000, 1'b0, 32'h0010_0093};
    vecs[1] = '{32'h8000_0004, 1'b0, 32'h0020_0113};
    vecs[2] = '{32'h8000_0002, 1'b1, 32'h0};
    vecs[3] = '{32'h8000_1000, 1'b1, 32'h0};
    vecs[4] = '{32'h7FFF_FFFC, 1'b1, 32'h0};
    vecs[5] = '{32'h8000_0FFC, 1'b0, 32'hCAFE_F00D};
    vecs[6] = '{32'h8000_0FFD, 1'b1, 32'h0};
    vecs[7] = '{32'hFFFF_FFFC, 1'b1, 32'h0};
    vecs[8] = '{32'h0000_0000, 1'b1, 32'h0};
    for (int i = 0; i < 9; i++)
      do_fetch(vecs[i].addr, vecs[i].err, vecs[i].data, 1'b0, '0, 32'h0, 0, $sformatf("vec%0d", i));

    do_fetch(32'h8000_0004, 1'b0, 32'h0020_0113, 1'b0, '0, 32'h0, 5, "backpressure");

    // Flush while waiting out the latency.
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_wait_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_wait_no_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    fetch_model(32'h8000_0004, 0, "after_flush_wait");

    // Flush while the response is presented; it must not come back.
    req_valid = 1'b1; req_addr = 32'h8000_0000; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("flush_resp_pre_valid", 32'(rsp_valid), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("flush_resp_no_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    fetch_model(32'h8000_0004, 0, "after_flush_resp");

    // Flush in IDLE blocks acceptance of a concurrent request.
    req_valid = 1'b1; req_addr = 32'h8000_0000; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_idle_no_accept", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end

    // Same-edge program write to the word being fetched.
    do_fetch(32'h8000_0000, 1'b0, 32'h0010_0093, 1'b1, AW'(0), 32'hDEAD_BEEF, 0, "same_edge_old");
    do_fetch(32'h8000_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, '0, 32'h0, 0, "same_edge_new");

    // Asynchronous reset during RESP.
    req_valid = 1'b1; req_addr = 32'h8000_0000; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("arst_pre_valid", 32'(rsp_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    chk("arst_rsp_data", rsp_data, 32'h0);
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1;
    do_fetch(32'h8000_0004, 1'b0, 32'h0020_0113, 1'b0, '0, 32'h0, 0, "arst_after");

    // Randomized fetches with stalls and concurrent program writes.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      logic e;
      logic [31:0] d;
      bit we;
      logic [AW-1:0] wa;
      logic [31:0] wd;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2);
      else if (sel == 7) a = $urandom;
      else if (sel == 8) a = BASE + (32'($urandom_range(0, DEPTH - 1)) << 2) + 32'($urandom_range(1, 3));
      else               a = BASE + 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
      model_fetch(a, e, d);
      we = ($urandom_range(0, 3) == 0);
      wa = ($urandom_range(0, 1) == 1) ? AW'((a - BASE) >> 2) : AW'($urandom);
      wd = $urandom;
      do_fetch(a, e, d, we, wa, wd, $urandom_range(0, 3), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
